// File: rtl/odd_issue_stage_if.sv
// odd_issue_stage_if: decode-to-issue and issue-to-odd-pipe signal bundle
// master: decode/odd-pipe side (drives in_* and flush); slave: the issue stage
interface odd_issue_stage_if;
  logic       flush;
  logic       in_valid;
  logic       in_ready;
  logic [6:0] in_instr_id;
  logic [2:0] in_unit_id;
  logic [3:0] in_latency;
  logic       in_reg_wr;
  logic [6:0] in_reg_dst;
  logic [6:0] in_ra_addr;
  logic [6:0] in_rb_addr;
  logic [6:0] in_rc_addr;
  logic       in_ra_used;
  logic       in_rb_used;
  logic       in_rc_used;
  logic [9:0] in_pc;
  logic       out_valid;
  logic [6:0] out_instr_id;
  logic [2:0] out_unit_id;
  logic [3:0] out_latency;
  logic       out_reg_wr;
  logic [6:0] out_reg_dst;
  logic [9:0] out_pc;
  logic [15:0] stall_cycles;
  modport master (
    output flush, in_valid, in_instr_id, in_unit_id, in_latency, in_reg_wr, in_reg_dst,
           in_ra_addr, in_rb_addr, in_rc_addr, in_ra_used, in_rb_used, in_rc_used, in_pc,
    input  in_ready, out_valid, out_instr_id, out_unit_id, out_latency, out_reg_wr,
           out_reg_dst, out_pc, stall_cycles
  );
  modport slave (
    input  flush, in_valid, in_instr_id, in_unit_id, in_latency, in_reg_wr, in_reg_dst,
           in_ra_addr, in_rb_addr, in_rc_addr, in_ra_used, in_rb_used, in_rc_used, in_pc,
    output in_ready, out_valid, out_instr_id, out_unit_id, out_latency, out_reg_wr,
           out_reg_dst, out_pc, stall_cycles
  );
endinterface

// File: rtl/odd_issue_stage.sv
// odd_issue_stage: odd-pipe issue stage with per-register write scoreboard, WAW ordering and flush
// Ports: clk; rst (async, active-low); bus (odd_issue_stage_if.slave: decode in_*, flush,
// registered out_* to the odd pipe, stall_cycles counter).
// Build option ODD_ISSUE_FWD_EN: sources count as ready once their result sits in a forwarding stage.
module odd_issue_stage #(
  parameter int         NUM_REGS = 128,
  parameter int         WB_EXTRA = 8,
  parameter logic [6:0] NOP_ID   = 7'd0
) (
  input logic clk,
  input logic rst,
  odd_issue_stage_if.slave bus
);
  typedef struct packed {
    logic [6:0] instr_id;
    logic [2:0] unit_id;
    logic [3:0] latency;
    logic       reg_wr;
    logic [6:0] reg_dst;
    logic [6:0] ra;
    logic [6:0] rb;
    logic [6:0] rc;
    logic       ra_used;
    logic       rb_used;
    logic       rc_used;
    logic [9:0] pc;
  } instr_t;
  typedef struct packed {
    logic       valid;
    logic [6:0] instr_id;
    logic [2:0] unit_id;
    logic [3:0] latency;
    logic       reg_wr;
    logic [6:0] reg_dst;
    logic [9:0] pc;
  } out_t;
  localparam logic [4:0] WB = 5'(WB_EXTRA);
  localparam out_t BUBBLE = '{1'b0, NOP_ID, 3'd0, 4'd0, 1'b0, 7'd0, 10'd0};
  logic        hold_valid_q, hold_valid_d;
  instr_t      hold_q, hold_d, in_instr;
  logic [4:0]  cnt_q [NUM_REGS];
  logic [4:0]  cnt_d [NUM_REGS];
  out_t        out_q, out_d;
  logic [15:0] stall_q, stall_d;
  logic [4:0]  set_val;
  logic        srcs_rdy, waw, issue, in_ready, capture;
  function automatic logic src_rdy(input logic used, input logic [4:0] c);
`ifdef ODD_ISSUE_FWD_EN
    return !used || c <= WB;
`else
    return !used || c == 5'd0;
`endif
  endfunction
  always_comb begin
    in_instr = '{bus.in_instr_id, bus.in_unit_id, bus.in_latency, bus.in_reg_wr, bus.in_reg_dst,
                 bus.in_ra_addr, bus.in_rb_addr, bus.in_rc_addr,
                 bus.in_ra_used, bus.in_rb_used, bus.in_rc_used, bus.in_pc};
    set_val  = {1'b0, hold_q.latency} + WB;
    srcs_rdy = src_rdy(hold_q.ra_used, cnt_q[hold_q.ra]) &&
               src_rdy(hold_q.rb_used, cnt_q[hold_q.rb]) &&
               src_rdy(hold_q.rc_used, cnt_q[hold_q.rc]);
    // an older in-flight write that would land later than ours must drain first
    waw      = hold_q.reg_wr && cnt_q[hold_q.reg_dst] > set_val;
    issue    = hold_valid_q && srcs_rdy && !waw && !bus.flush;
    in_ready = !hold_valid_q || issue;
    capture  = bus.in_valid && in_ready && !bus.flush;
    hold_valid_d = bus.flush ? 1'b0 : capture ? 1'b1 : issue ? 1'b0 : hold_valid_q;
    hold_d   = capture ? in_instr : hold_q;
    for (int i = 0; i < NUM_REGS; i++)
      cnt_d[i] = (issue && hold_q.reg_wr && hold_q.reg_dst == 7'(i)) ? set_val :
                 cnt_q[i] != 5'd0 ? cnt_q[i] - 5'd1 : 5'd0;
    out_d    = issue ? '{1'b1, hold_q.instr_id, hold_q.unit_id, hold_q.latency, hold_q.reg_wr,
                         hold_q.reg_dst, hold_q.pc} : BUBBLE;
    stall_d  = (hold_valid_q && !issue && stall_q != 16'hFFFF) ? stall_q + 16'd1 : stall_q;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hold_valid_q <= 1'b0;
      hold_q       <= '0;
      for (int i = 0; i < NUM_REGS; i++) cnt_q[i] <= 5'd0;
      out_q        <= BUBBLE;
      stall_q      <= 16'd0;
    end else begin
      hold_valid_q <= hold_valid_d;
      hold_q       <= hold_d;
      for (int i = 0; i < NUM_REGS; i++) cnt_q[i] <= cnt_d[i];
      out_q        <= out_d;
      stall_q      <= stall_d;
    end
  end
  assign bus.in_ready     = in_ready;
  assign bus.out_valid    = out_q.valid;
  assign bus.out_instr_id = out_q.instr_id;
  assign bus.out_unit_id  = out_q.unit_id;
  assign bus.out_latency  = out_q.latency;
  assign bus.out_reg_wr   = out_q.reg_wr;
  assign bus.out_reg_dst  = out_q.reg_dst;
  assign bus.out_pc       = out_q.pc;
  assign bus.stall_cycles = stall_q;
endmodule

// File: doc/odd_issue_stage.md
Name: odd_issue_stage

Overview:
- Issue/hazard stage directly upstream of the odd pipe (permute, load/store, branch units); receives decoded odd-slot instructions from decode and presents one instruction per cycle to the odd pipe's decoded-field inputs.
- Keeps a per-register scoreboard of pending odd-pipe writes and holds an instruction until its source operands are ready, inserting bubbles otherwise.
- Also handles write-after-write (WAW) ordering and branch flush.

Parameters:
- NUM_REGS, 128, architectural register count (7-bit address).
- WB_EXTRA, 8, cycles from the end of a unit's latency until register-file writeback (7 packed stages plus WB register).
- NOP_ID, 7'd0, instr_id driven on bubble cycles.

Ports:
- clk  input  1  clock
- rst  input  1  asynchronous, active-low reset
- flush  input  1  branch-taken flush; kills the held instruction and the output slot
- in_valid  input  1  decode presents an instruction
- in_ready  output  1  stage accepts the instruction this cycle
- in_instr_id  input  7  decoded instruction ID
- in_unit_id  input  3  4=permute, 5=load/store, 6=branch
- in_latency  input  4  unit latency
- in_reg_wr  input  1  instruction writes reg_dst
- in_reg_dst  input  7  destination register
- in_ra_addr, in_rb_addr, in_rc_addr  input  7 each  source register addresses
- in_ra_used, in_rb_used, in_rc_used  input  1 each  source is read
- in_pc  input  10  instruction PC
- out_valid  output  1  issued instruction valid
- out_instr_id  output  7
- out_unit_id  output  3
- out_latency  output  4
- out_reg_wr  output  1
- out_reg_dst  output  7
- out_pc  output  10
- stall_cycles  output  16  saturating count of cycles with hold_valid and no issue

Behaviour:
- Reset (rst=0, async):
  - hold_valid=0 and all scoreboard counters=0.
  - All out_* = 0, out_instr_id=NOP_ID, stall_cycles=0.
- Hold register: one entry.
  - in_ready = !hold_valid || issue (combinational).
  - Capture occurs on in_valid && in_ready && !flush.
- Scoreboard: 5-bit counter per register.
  - Issue with reg_wr loads cnt[reg_dst] = latency + WB_EXTRA. No overflow: max 15+8=23.
  - Every cycle, every other nonzero counter decrements by 1.
  - Set and decrement on the same register in the same cycle: set wins.
- Source readiness: ready(r) = !used || cnt[r]==0.
- WAW stall: reg_wr && cnt[reg_dst] > latency + WB_EXTRA. Guarantees in-order writeback per register.
- Issue condition: hold_valid && all sources ready && !WAW && !flush.
- Output register, updated every edge:
  - On issue: copy held fields, out_valid=1.
  - Otherwise: bubble (out_valid=0, out_reg_wr=0, out_instr_id=NOP_ID, other fields 0).
- Latency:
  - Instruction presented at edge k is captured; with no hazard it appears on out_* after edge k+1.
  - Back-to-back independent instructions give one issue per cycle.
- Flush:
  - Clears hold_valid and makes the next output a bubble.
  - The incoming instruction that cycle is dropped (in_ready still reports the normal value).
  - Scoreboard is untouched, because already-issued writes still complete.
- Stalled instruction: held fields are stable; in_ready=0 until issue.
- Store instructions (reg_wr=0): no scoreboard update; their rc source is checked like any other source.
- stall_cycles saturates at 16'hFFFF.

Optional Feature:
- ODD_ISSUE_FWD_EN
  - Defined: a source is ready when cnt[r] <= WB_EXTRA, i.e. the result exists in a packed forwarding stage. This assumes the forwarding unit supplies it.
  - Undefined: ready only at cnt[r]==0, i.e. after register-file writeback.
  - WAW rule is identical in both builds.

Test Plan:
- Reset asserted mid-stall with hold_valid=1, cnt[5]=12 -> immediately out_valid=0, in_ready=1, stall_cycles=0; after release an instruction reading r5 issues on the next edge.
- Permute, latency 3, writes r10; next instruction reads ra=r10 -> macro off: 11 bubble cycles, then issue; macro on: 3 bubbles; stall_cycles increments by 11 or 3.
- Ten independent instructions presented back-to-back -> ten consecutive out_valid=1 cycles, in_ready held at 1, PCs in order.
- Load (latency 6) writes r20, followed by permute (latency 3) writing r20 -> WAW stall until cnt[20] <= 11, i.e. 3 bubble cycles.
- Held instruction stalled on a hazard when flush is asserted -> next output is a bubble, hold_valid=0, the dropped instruction never appears, cnt values keep decrementing.
- Store with rc=r7 while cnt[7]=2 (macro off) -> 2 bubbles, then issue with out_reg_wr=0, and the scoreboard is unchanged.
